mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency memory between instruction fetch (IF, read-only)
//  and the data-memory stage (DM, read/write). Data requests get priority (older instruction),

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 60 ++++++
 rtl/mem_port_arbiter_age_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
//   Shared types for the instruction/data memory port arbiter.
//   arb_state_t : transaction FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   arb_owner_t : which requester owns the outstanding memory transaction
//   age_width() : bit width needed to hold an age count of 0..max
package mem_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_t;

   function automatic int unsigned age_width(input int unsigned max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch port, data port, memory port and stall outputs of the
//   arbiter. Modport slave is the arbiter's view; modport master is the view
//   of the surrounding pipeline and memory.
//   Fetch  : if_req, if_addr -> if_valid, if_rdata
//   Data   : dm_req, dm_we, dm_addr, dm_wdata, dm_be -> dm_valid, dm_rdata
//   Memory : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_gnt, mem_rvalid, mem_rdata
//   Stalls : stall_fetch, stall_mem
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [BE_W-1:0]   dm_be;
   logic              dm_valid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_be;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_fetch;
   logic              stall_mem;

   modport slave (
      input  if_req, if_addr,
      output if_valid, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_valid, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output stall_fetch, stall_mem
   );

   modport master (
      output if_req, if_addr,
      input  if_valid, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_valid, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  stall_fetch, stall_mem
   );

endinterface

// File: rtl/mem_port_arbiter_age_counter.sv
// arb_age_counter
//   Counts consecutive data-port grants taken while a fetch is waiting.
//   Saturates at MAX, never wraps; clear has priority over increment.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : a data grant was made while fetch was requesting
//   clr        : fetch was granted, or fetch is not requesting
//   sat        : count has reached MAX, fetch must win the next contest
module arb_age_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic sat
);
   localparam int unsigned W = age_width(MAX);

   logic [W-1:0] age;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age <= '0;
      end else if (clr) begin
         age <= '0;
      end else if (inc && !sat) begin
         age <= age + W'(1);
      end
   end

   assign sat = (age == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, variable-latency memory between instruction
//   fetch (read-only) and the data stage (read/write). Data wins contention
//   unless fetch has lost STARVE_MAX consecutive contests. One outstanding
//   memory transaction at a time.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset; abandons any transaction
//   bus   : fetch, data, memory ports and stall outputs (slave modport)
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.slave  bus
);
   localparam int unsigned BE_W = DATA_W / 8;

   arb_state_t        state;
   arb_owner_t        owner;
   logic              req_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;

   logic              age_sat;
   logic              grant;
   logic              pick_dm;
   logic              done;
   logic              if_done;
   logic              dm_done;

   // Data wins a contest unless fetch has aged out.
   assign grant   = (state == ARB_IDLE) && (bus.if_req || bus.dm_req);
   assign pick_dm = bus.dm_req && !(bus.if_req && age_sat);

   // Completion either in WAIT, or in ISSUE when grant and response coincide.
   // mem_rvalid in IDLE, or in ISSUE without grant, is ignored.
   assign done = bus.mem_rvalid &&
                 ((state == ARB_WAIT) || ((state == ARB_ISSUE) && bus.mem_gnt));

   arb_age_counter #(.MAX(STARVE_MAX)) u_age (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (grant && pick_dm && bus.if_req),
      .clr   (!bus.if_req || (grant && !pick_dm)),
      .sat   (age_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ARB_IDLE;
         owner   <= OWN_NONE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grant) begin
                  req_q <= 1'b1;
                  state <= ARB_ISSUE;
                  if (pick_dm) begin
                     owner   <= OWN_DM;
                     we_q    <= bus.dm_we;
                     addr_q  <= bus.dm_addr;
                     wdata_q <= bus.dm_wdata;
                     be_q    <= bus.dm_we ? bus.dm_be : '1;
                  end else begin
                     owner   <= OWN_IF;
                     we_q    <= 1'b0;
                     addr_q  <= bus.if_addr;
                     wdata_q <= '0;
                     be_q    <= '1;
                  end
               end
            end
            ARB_ISSUE: begin
               if (bus.mem_gnt) begin
                  req_q <= 1'b0;
                  if (bus.mem_rvalid) begin
                     state <= ARB_IDLE;
                     owner <= OWN_NONE;
                  end else begin
                     state <= ARB_WAIT;
                  end
               end
            end
            ARB_WAIT: begin
               if (bus.mem_rvalid) begin
                  state <= ARB_IDLE;
                  owner <= OWN_NONE;
               end
            end
            default: begin
               state <= ARB_IDLE;
               owner <= OWN_NONE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign if_done = done && (owner == OWN_IF);
   assign dm_done = done && (owner == OWN_DM);

   assign bus.if_valid  = if_done;
   assign bus.dm_valid  = dm_done;
   assign bus.if_rdata  = if_done ? bus.mem_rdata : '0;
   assign bus.dm_rdata  = dm_done ? bus.mem_rdata : '0;

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_be    = be_q;

   assign bus.stall_fetch = bus.if_req && !if_done;
   assign bus.stall_mem   = bus.dm_req && !dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scoreboard bench: stimulus pushes expected memory grants and
//   expected read data; a negedge monitor pops and compares whenever the
//   arbiter grants or emits a valid pulse.
module tb_mem_port_arbiter;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } gnt_t;

   logic clk;
   logic rst_n;

   int unsigned pass_cnt;
   int unsigned total_cnt;

   gnt_t        gnt_q[$];
   logic [31:0] if_q[$];
   logic [31:0] dm_q[$];
   gnt_t        mon_g;
   logic [31:0] mon_d;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (bus.mem_req && bus.mem_gnt) begin
         if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
         end else begin
            mon_g = gnt_q.pop_front();
            chk("gnt_we",   32'(bus.mem_we), 32'(mon_g.we));
            chk("gnt_addr", bus.mem_addr,    mon_g.addr);
            chk("gnt_be",   32'(bus.mem_be), 32'(mon_g.be));
            if (mon_g.we) chk("gnt_wdata", bus.mem_wdata, mon_g.wdata);
         end
      end
      if (bus.if_valid) begin
         if (if_q.size() == 0) begin
            chk("if_valid_unexpected", 32'(bus.if_valid), 32'd0);
         end else begin
            mon_d = if_q.pop_front();
            chk("if_rdata", bus.if_rdata, mon_d);
         end
      end
      if (bus.dm_valid) begin
         if (dm_q.size() == 0) begin
            chk("dm_valid_unexpected", 32'(bus.dm_valid), 32'd0);
         end else begin
            mon_d = dm_q.pop_front();
            chk("dm_rdata", bus.dm_rdata, mon_d);
         end
      end
   end

   // Memory responder: entered just after a rising edge. Waits for mem_req,
   // holds grant off gdly cycles (checking stability), then grants; response
   // follows rdly cycles after the grant (0 = same cycle).
   task automatic serve(input int gdly, input int rdly, input logic [31:0] data);
      int n;
      logic        c_we;
      logic [31:0] c_addr;
      logic [3:0]  c_be;
      n = 0;
      while (!bus.mem_req && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.mem_req) begin
         chk("serve_req_timeout", 32'd0, 32'd1);
         return;
      end
      c_we   = bus.mem_we;
      c_addr = bus.mem_addr;
      c_be   = bus.mem_be;
      for (int i = 0; i < gdly; i++) begin
         @(posedge clk); #1;
         chk("hold_req",      32'(bus.mem_req),   32'd1);
         chk("hold_addr",     bus.mem_addr,       c_addr);
         chk("hold_we",       32'(bus.mem_we),    32'(c_we));
         chk("hold_be",       32'(bus.mem_be),    32'(c_be));
         chk("hold_no_valid", 32'({bus.if_valid, bus.dm_valid}), 32'd0);
         chk("hold_stall",    32'({bus.stall_fetch, bus.stall_mem}),
                              32'({bus.if_req, bus.dm_req}));
      end
      bus.mem_gnt = 1'b1;
      if (rdly == 0) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = data;
      end
      @(posedge clk); #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rdly > 0) begin
         for (int i = 1; i < rdly; i++) begin
            @(posedge clk); #1;
         end
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = data;
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      rst_n = 1'b0;
      bus.if_req = 1'b1;     bus.if_addr = '0;
      bus.dm_req = 1'b1;     bus.dm_we = 1'b0;   bus.dm_addr = '0;
      bus.dm_wdata = '0;     bus.dm_be = '0;
      bus.mem_gnt = 1'b0;    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

      // Reset values; stalls follow the requests while held in reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall_fetch", 32'(bus.stall_fetch), 32'd1);
      chk("rst_stall_mem",   32'(bus.stall_mem),   32'd1);
      chk("rst_mem_req",     32'(bus.mem_req),     32'd0);
      chk("rst_mem_we",      32'(bus.mem_we),      32'd0);
      chk("rst_mem_addr",    bus.mem_addr,         32'd0);
      chk("rst_mem_wdata",   bus.mem_wdata,        32'd0);
      chk("rst_mem_be",      32'(bus.mem_be),      32'd0);
      chk("rst_valids",      32'({bus.if_valid, bus.dm_valid}), 32'd0);
      chk("rst_if_rdata",    bus.if_rdata,         32'd0);
      chk("rst_dm_rdata",    bus.dm_rdata,         32'd0);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fetch only: gnt at 1, rvalid at 2 -> if_valid at 2
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      gnt_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'hF, wdata: 32'd0});
      if_q.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      chk("t1_c0_stall_fetch", 32'(bus.stall_fetch), 32'd1);
      chk("t1_c0_mem_req",     32'(bus.mem_req),     32'd0);
      @(posedge clk); #1;
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk("t1_c1_mem_req",     32'(bus.mem_req),     32'd1);
      chk("t1_c1_stall_fetch", 32'(bus.stall_fetch), 32'd1);
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_c2_if_valid",    32'(bus.if_valid),    32'd1);
      chk("t1_c2_stall_fetch", 32'(bus.stall_fetch), 32'd0);
      chk("t1_c2_mem_req",     32'(bus.mem_req),     32'd0);
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0; bus.if_req = 1'b0;
      @(negedge clk);
      chk("t1_c3_if_valid",    32'(bus.if_valid),    32'd0);
      @(posedge clk); #1;

      // Fetch and data store in the same cycle: store first, then fetch
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h200;
      bus.dm_wdata = 32'h1234_5678; bus.dm_be = 4'b0011;
      gnt_q.push_back('{we: 1'b1, addr: 32'h200, be: 4'b0011, wdata: 32'h1234_5678});
      dm_q.push_back(32'hA0A0_A0A0);
      gnt_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'd0});
      if_q.push_back(32'h3333_3333);
      serve(1, 1, 32'hA0A0_A0A0);
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      serve(0, 1, 32'h3333_3333);
      bus.if_req = 1'b0;
      @(posedge clk); #1;

      // Continuous contention: DM,DM,DM,DM,IF repeating
      bus.if_req = 1'b1; bus.if_addr = 32'h600;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500; bus.dm_be = 4'b0101;
      for (int k = 0; k < 10; k++) begin
         if ((k % 5) == 4) begin
            gnt_q.push_back('{we: 1'b0, addr: 32'h600, be: 4'hF, wdata: 32'd0});
            if_q.push_back(32'h1000_0000 + 32'(k));
         end else begin
            gnt_q.push_back('{we: 1'b0, addr: 32'h500, be: 4'hF, wdata: 32'd0});
            dm_q.push_back(32'h1000_0000 + 32'(k));
         end
         serve(0, 1, 32'h1000_0000 + 32'(k));
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      @(posedge clk); #1;

      // Grant held off 5 cycles: request and fields stable, no valid
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h440;
      bus.dm_wdata = 32'h5555_AAAA; bus.dm_be = 4'b1100;
      gnt_q.push_back('{we: 1'b1, addr: 32'h440, be: 4'b1100, wdata: 32'h5555_AAAA});
      dm_q.push_back(32'h0BAD_F00D);
      serve(5, 1, 32'h0BAD_F00D);
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      @(posedge clk); #1;

      // Reset during WAIT, then a late response that must be ignored
      bus.if_req = 1'b1; bus.if_addr = 32'h700;
      gnt_q.push_back('{we: 1'b0, addr: 32'h700, be: 4'hF, wdata: 32'd0});
      for (int n = 0; n < 20 && !bus.mem_req; n++) begin
         @(posedge clk); #1;
      end
      chk("t5_mem_req_seen", 32'(bus.mem_req), 32'd1);
      bus.mem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_mem_req",     32'(bus.mem_req),     32'd0);
      chk("t5_rst_mem_addr",    bus.mem_addr,         32'd0);
      chk("t5_rst_mem_be",      32'(bus.mem_be),      32'd0);
      chk("t5_rst_valids",      32'({bus.if_valid, bus.dm_valid}), 32'd0);
      chk("t5_rst_stall_fetch", 32'(bus.stall_fetch), 32'd1);
      bus.if_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
      #1;
      chk("t5_late_rvalid_no_valid", 32'({bus.if_valid, bus.dm_valid}), 32'd0);
      chk("t5_late_rvalid_if_rdata", bus.if_rdata, 32'd0);
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      @(posedge clk); #1;

      // Grant and response together in ISSUE; then spurious response in IDLE
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h800;
      gnt_q.push_back('{we: 1'b0, addr: 32'h800, be: 4'hF, wdata: 32'd0});
      dm_q.push_back(32'hCAFE_F00D);
      serve(0, 0, 32'hCAFE_F00D);
      bus.dm_req = 1'b0;
      @(negedge clk);
      chk("t6_idle_mem_req", 32'(bus.mem_req), 32'd0);
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("t6_spurious_no_valid", 32'({bus.if_valid, bus.dm_valid}), 32'd0);
      chk("t6_spurious_mem_req",  32'(bus.mem_req), 32'd0);
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("end_gnt_q_empty", 32'(gnt_q.size()), 32'd0);
      chk("end_if_q_empty",  32'(if_q.size()),  32'd0);
      chk("end_dm_q_empty",  32'(dm_q.size()),  32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
